instr_decoder: RTL and testbench
================================

INSTR_DECODER -- requirements
Module: instr_decoder

Interface
REQ-001 The block SHALL run on one clock; reset SHALL be synchronous and active-low.
REQ-002 clk  input  1  peripheral clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 cs_n  input  1  serial frame select; high = no frame active.
REQ-005 byte_sync  input  1  one-cycle pulse: rx_byte holds a complete received byte.
REQ-006 rx_byte  input  8  byte from serial bridge, valid when byte_sync=1.
REQ-007 tx_byte  output  8  byte the serial bridge shifts out on the next transfer.
REQ-008 read  output  1  register read strobe toward the register block.
REQ-009 write  output  1  register write strobe toward the register block.
REQ-010 addr  output  6  register address.
REQ-011 data_write  output  8  write data toward the register block.
REQ-012 data_read  input  8  read data from the register block, combinationally valid while read=1.
REQ-013 err  output  1  one-cycle error pulse.

Function
REQ-014 Frame format SHALL be two bytes: setup byte (bit7 1=write, 0=read; bit6 ignored; bits5:0 address), then data byte (write data, or dummy for read).
REQ-015 FSM states SHALL be IDLE, RD_ACC, WAIT_DATA, WR_ACC.
REQ-016 IDLE + byte_sync: addr<=rx_byte[5:0], rw<=rx_byte[7]; next RD_ACC if read, WAIT_DATA if write.
REQ-017 RD_ACC SHALL last exactly one cycle with read=1; tx_byte<=data_read at that cycle's closing edge; next WAIT_DATA.
REQ-018 WAIT_DATA + byte_sync, write frame: data_write<=rx_byte, next WR_ACC; read frame: byte discarded, next IDLE.
REQ-019 WR_ACC SHALL last exactly one cycle with write=1; next IDLE.
REQ-020 read and write SHALL be registered, never both 1, each high for exactly one cycle per frame.
REQ-021 Latency: read asserts 1 cycle after setup byte_sync; write asserts 1 cycle after data byte_sync.
REQ-022 addr and data_write SHALL hold their last captured values between frames; tx_byte SHALL hold until the next RD_ACC.
REQ-023 byte_sync in RD_ACC or WR_ACC SHALL be ignored (no capture, state unaffected) and err SHALL pulse next cycle.
REQ-024 cs_n=1 SHALL force IDLE at the next edge from IDLE, RD_ACC or WAIT_DATA, discarding the partial frame; WR_ACC SHALL complete its write first.
REQ-025 byte_sync with cs_n=1 SHALL be ignored.
REQ-026 byte_sync in WAIT_DATA coincident with cs_n=1: cs_n wins; no write issued.

Reset
REQ-027 rst_n=0 at a rising edge SHALL set state=IDLE, read=0, write=0, err=0, addr=6'h00, data_write=8'h00, tx_byte=8'h00, overriding any in-progress frame (no strobe issued afterwards for it).

Configuration
REQ-028 Macro ADDR_RANGE_CHECK_EN defined: a setup byte with address >6'h0D SHALL go to WAIT_DATA without RD_ACC, load tx_byte=8'hEE, pulse err next cycle, and suppress that frame's read/write strobe; data byte still consumed.
REQ-029 ADDR_RANGE_CHECK_EN undefined: all 64 addresses SHALL be forwarded; err SHALL pulse only per REQ-023.

Verification
REQ-030 Write frame 8'h80, 8'h34 -> one write pulse, addr=6'h00, data_write=8'h34, read never high.
REQ-031 Read frame 8'h0A, 8'h00 with data_read=8'h5A while read=1 -> read pulse 1 cycle after first byte_sync, tx_byte=8'h5A, no write.
REQ-032 Setup 8'h83, cs_n raised before data byte -> IDLE, no write; next frame 8'h84, 8'h11 writes addr 6'h04 data 8'h11.
REQ-033 rst_n low during WAIT_DATA of write frame 8'h8C -> all outputs at reset values, no write pulse, next frame decodes normally.
REQ-034 byte_sync during WR_ACC -> err pulse 1 cycle, byte ignored, write pulse still exactly 1 cycle.
REQ-035 With ADDR_RANGE_CHECK_EN, frame 8'h9F, 8'hFF -> no write, err pulse, tx_byte=8'hEE; without macro -> write to addr 6'h1F, err stays 0.

Source files
------------

// File: rtl/instr_decoder_if.sv
// instr_decoder_if -- bus bundle between the serial bridge, the instruction
// decoder and the register block.
//   Serial side : cs_n, byte_sync, rx_byte (in to decoder), tx_byte (out)
//   Register side: read, write, addr, data_write, err (out), data_read (in)
// Modports:
//   master - the decoder (drives strobes, address, write data, tx_byte)
//   slave  - the environment (bridge + register block)
interface instr_decoder_if;
    logic       cs_n;
    logic       byte_sync;
    logic [7:0] rx_byte;
    logic [7:0] tx_byte;
    logic       read;
    logic       write;
    logic [5:0] addr;
    logic [7:0] data_write;
    logic [7:0] data_read;
    logic       err;

    modport master (
        input  cs_n, byte_sync, rx_byte, data_read,
        output tx_byte, read, write, addr, data_write, err
    );

    modport slave (
        output cs_n, byte_sync, rx_byte, data_read,
        input  tx_byte, read, write, addr, data_write, err
    );
endinterface

// File: rtl/instr_decoder.sv
// instr_decoder -- decodes two-byte serial frames (setup byte, data byte)
// into single-cycle register read/write strobes.
//   clk   : clock, all state updates on rising edge
//   rst_n : synchronous active-low reset
//   bus   : instr_decoder_if.master (serial bytes in, register bus out,
//           tx_byte back to the bridge, err pulse)
// Setup byte: bit7 1=write/0=read, bit6 ignored, bits5:0 address.
// Optional feature macro ADDR_RANGE_CHECK_EN: setup bytes addressing above
// 6'h0D are rejected (tx_byte=8'hEE, err pulse, no strobe for that frame).
module instr_decoder (
    input  logic                   clk,
    input  logic                   rst_n,
    instr_decoder_if.master        bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RD_ACC    = 2'd1,
        WAIT_DATA = 2'd2,
        WR_ACC    = 2'd3
    } state_t;

    state_t state;
    logic   rw;        // 1 = current frame is a write
    logic   rejected;  // current frame was refused by the address check
    logic   addr_oor;  // incoming setup byte addresses outside the map

    // Bytes only count while the frame is selected.
    logic   byte_ok;
    assign byte_ok = bus.byte_sync & ~bus.cs_n;

`ifdef ADDR_RANGE_CHECK_EN
    assign addr_oor = (bus.rx_byte[5:0] > 6'h0D);
`else
    assign addr_oor = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            rw             <= 1'b0;
            rejected       <= 1'b0;
            bus.read       <= 1'b0;
            bus.write      <= 1'b0;
            bus.err        <= 1'b0;
            bus.addr       <= '0;
            bus.data_write <= '0;
            bus.tx_byte    <= '0;
        end else begin
            // Strobes are single-cycle by construction: cleared every edge
            // and only set on the transition into their access state.
            bus.read  <= 1'b0;
            bus.write <= 1'b0;
            bus.err   <= 1'b0;

            case (state)
                IDLE: begin
                    if (byte_ok) begin
                        bus.addr <= bus.rx_byte[5:0];
                        rw       <= bus.rx_byte[7];
                        if (addr_oor) begin
                            rejected    <= 1'b1;
                            bus.tx_byte <= 8'hEE;
                            bus.err     <= 1'b1;
                            state       <= WAIT_DATA;
                        end else begin
                            rejected <= 1'b0;
                            if (bus.rx_byte[7]) begin
                                state <= WAIT_DATA;
                            end else begin
                                bus.read <= 1'b1;
                                state    <= RD_ACC;
                            end
                        end
                    end
                end

                RD_ACC: begin
                    // The read strobe was issued this cycle, so its data is
                    // captured even if the frame is being aborted.
                    bus.tx_byte <= bus.data_read;
                    if (byte_ok) begin
                        bus.err <= 1'b1;
                    end
                    state <= bus.cs_n ? IDLE : WAIT_DATA;
                end

                WAIT_DATA: begin
                    if (bus.cs_n) begin
                        state <= IDLE;
                    end else if (bus.byte_sync) begin
                        if (rw && !rejected) begin
                            bus.data_write <= bus.rx_byte;
                            bus.write      <= 1'b1;
                            state          <= WR_ACC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                WR_ACC: begin
                    // Write always completes; cs_n is not checked here.
                    if (byte_ok) begin
                        bus.err <= 1'b1;
                    end
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_decoder.sv
// tb_instr_decoder -- scoreboard bench for instr_decoder.
// Stimulus pushes expected strobe events and output snapshots into queues;
// a monitor on the falling edge pops and compares them.
module tb_instr_decoder;

    localparam int EV_RD  = 0;
    localparam int EV_WR  = 1;
    localparam int EV_ERR = 2;

    typedef struct {
        int         kind;
        logic [5:0] addr;
        logic [7:0] data;
    } ev_t;

    typedef struct {
        string      name;
        logic [5:0] addr;
        logic [7:0] dw;
        logic [7:0] tx;
        logic       rd;
        logic       wr;
        logic       er;
    } snap_t;

    logic clk = 1'b0;
    logic rst_n;
    logic done = 1'b0;

    ev_t   exp_q[$];
    snap_t snap_q[$];

    int n_checks = 0;
    int n_fails  = 0;

    instr_decoder_if bus ();

    instr_decoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Register block model: read data depends on address.
    assign bus.data_read = bus.read ? (8'h50 ^ {2'b00, bus.addr}) : 8'h00;

    task automatic exp_ev(input int k, input logic [5:0] a, input logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic snap(input string nm, input logic [5:0] a, input logic [7:0] dw,
                        input logic [7:0] tx, input logic rd, input logic wr, input logic er);
        snap_t s;
        s.name = nm;
        s.addr = a;
        s.dw   = dw;
        s.tx   = tx;
        s.rd   = rd;
        s.wr   = wr;
        s.er   = er;
        snap_q.push_back(s);
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_byte   = b;
        bus.byte_sync = 1'b1;
        @(posedge clk);
        #1;
        bus.byte_sync = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n         = 1'b0;
        bus.cs_n      = 1'b1;
        bus.byte_sync = 1'b0;
        bus.rx_byte   = 8'h00;
        idle(2);
        snap("reset_state", 6'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        idle(1);

        // Write frame 80,34
        bus.cs_n = 1'b0;
        exp_ev(EV_WR, 6'h00, 8'h34);
        send(8'h80);
        idle(1);
        send(8'h34);
        snap("wr_latency", 6'h00, 8'h34, 8'h00, 1'b0, 1'b1, 1'b0);
        idle(3);
        snap("wr_hold", 6'h00, 8'h34, 8'h00, 1'b0, 1'b0, 1'b0);
        bus.cs_n = 1'b1;
        idle(2);

        // Read frame 0A,00 -> data_read 5A
        bus.cs_n = 1'b0;
        exp_ev(EV_RD, 6'h0A, 8'h5A);
        send(8'h0A);
        snap("rd_latency", 6'h0A, 8'h34, 8'h00, 1'b1, 1'b0, 1'b0);
        idle(1);
        send(8'h00);
        idle(2);
        snap("rd_hold", 6'h0A, 8'h34, 8'h5A, 1'b0, 1'b0, 1'b0);
        bus.cs_n = 1'b1;
        idle(2);

        // Setup 83 aborted by cs_n, then frame 84,11
        bus.cs_n = 1'b0;
        send(8'h83);
        bus.cs_n = 1'b1;
        idle(2);
        snap("abort_no_write", 6'h03, 8'h34, 8'h5A, 1'b0, 1'b0, 1'b0);
        bus.cs_n = 1'b0;
        exp_ev(EV_WR, 6'h04, 8'h11);
        send(8'h84);
        idle(1);
        send(8'h11);
        idle(2);
        snap("after_abort_wr", 6'h04, 8'h11, 8'h5A, 1'b0, 1'b0, 1'b0);
        bus.cs_n = 1'b1;
        idle(2);

        // Reset during WAIT_DATA of write frame 8C
        bus.cs_n = 1'b0;
        send(8'h8C);
        rst_n = 1'b0;
        idle(1);
        snap("reset_mid_frame", 6'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        idle(2);
        exp_ev(EV_WR, 6'h05, 8'h77);
        send(8'h85);
        idle(1);
        send(8'h77);
        idle(2);
        snap("after_reset_wr", 6'h05, 8'h77, 8'h00, 1'b0, 1'b0, 1'b0);
        bus.cs_n = 1'b1;
        idle(2);

        // byte_sync during WR_ACC
        bus.cs_n = 1'b0;
        exp_ev(EV_WR, 6'h02, 8'hAB);
        exp_ev(EV_ERR, 6'h00, 8'h00);
        send(8'h82);
        idle(1);
        send(8'hAB);
        send(8'hCC);
        snap("wracc_err", 6'h02, 8'hAB, 8'h00, 1'b0, 1'b0, 1'b1);
        idle(2);
        snap("wracc_ignored", 6'h02, 8'hAB, 8'h00, 1'b0, 1'b0, 1'b0);
        bus.cs_n = 1'b1;
        idle(2);

        // Frame 9F,FF (address above 0D)
        bus.cs_n = 1'b0;
`ifdef ADDR_RANGE_CHECK_EN
        exp_ev(EV_ERR, 6'h00, 8'h00);
        send(8'h9F);
        snap("oor_err", 6'h1F, 8'hAB, 8'hEE, 1'b0, 1'b0, 1'b1);
        idle(1);
        send(8'hFF);
        idle(2);
        snap("oor_hold", 6'h1F, 8'hAB, 8'hEE, 1'b0, 1'b0, 1'b0);
`else
        exp_ev(EV_WR, 6'h1F, 8'hFF);
        send(8'h9F);
        snap("hi_addr_setup", 6'h1F, 8'hAB, 8'h00, 1'b0, 1'b0, 1'b0);
        idle(1);
        send(8'hFF);
        idle(2);
        snap("hi_addr_wr", 6'h1F, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
`endif
        bus.cs_n = 1'b1;
        idle(5);
        done = 1'b1;
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic       tx_pend;
        logic [7:0] tx_exp;
        ev_t        e;
        snap_t      s;
        tx_pend = 1'b0;
        tx_exp  = 8'h00;
        forever begin
            @(negedge clk);
            if (tx_pend) begin
                n_checks++;
                if (bus.tx_byte !== tx_exp) begin
                    n_fails++;
                    $display("FAIL tx_after_read: got %02h expected %02h", bus.tx_byte, tx_exp);
                end
                tx_pend = 1'b0;
            end
            while (snap_q.size() > 0) begin
                s = snap_q.pop_front();
                n_checks++;
                if (bus.addr !== s.addr || bus.data_write !== s.dw || bus.tx_byte !== s.tx ||
                    bus.read !== s.rd || bus.write !== s.wr || bus.err !== s.er) begin
                    n_fails++;
                    $display("FAIL %s: got addr=%02h dw=%02h tx=%02h rd=%b wr=%b err=%b expected addr=%02h dw=%02h tx=%02h rd=%b wr=%b err=%b",
                             s.name, bus.addr, bus.data_write, bus.tx_byte, bus.read, bus.write, bus.err,
                             s.addr, s.dw, s.tx, s.rd, s.wr, s.er);
                end
            end
            if (bus.read === 1'b1 && bus.write === 1'b1) begin
                n_checks++;
                n_fails++;
                $display("FAIL rd_wr_overlap: got read=1 write=1 expected at most one");
            end
            if (bus.read === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fails++;
                    $display("FAIL unexpected_read: got read at addr %02h expected no strobe", bus.addr);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != EV_RD || bus.addr !== e.addr) begin
                        n_fails++;
                        $display("FAIL read_event: got read addr=%02h expected kind=%0d addr=%02h",
                                 bus.addr, e.kind, e.addr);
                    end
                    if (e.kind == EV_RD) begin
                        tx_pend = 1'b1;
                        tx_exp  = e.data;
                    end
                end
            end
            if (bus.write === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fails++;
                    $display("FAIL unexpected_write: got write addr=%02h data=%02h expected no strobe",
                             bus.addr, bus.data_write);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != EV_WR || bus.addr !== e.addr || bus.data_write !== e.data) begin
                        n_fails++;
                        $display("FAIL write_event: got addr=%02h data=%02h expected kind=%0d addr=%02h data=%02h",
                                 bus.addr, bus.data_write, e.kind, e.addr, e.data);
                    end
                end
            end
            if (bus.err === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fails++;
                    $display("FAIL unexpected_err: got err=1 expected err=0");
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != EV_ERR) begin
                        n_fails++;
                        $display("FAIL err_event: got err pulse expected kind=%0d", e.kind);
                    end
                end
            end
            if (done) begin
                n_checks++;
                if (exp_q.size() != 0 || snap_q.size() != 0) begin
                    n_fails++;
                    $display("FAIL drain: got %0d events %0d snapshots pending expected 0 0",
                             exp_q.size(), snap_q.size());
                end
                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
                $finish;
            end
        end
    end

    // Run-time bound.
    initial begin
        #100000;
        $display("FAIL watchdog: got no completion expected done within 100000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
